// File: rtl/mdc_rx_pkg.sv
// Shared types and helpers for the multi_dataflow stream receiver.
// Holds the FSM state type, configuration IDs and the ID-to-frame-size mapping.
package mdc_rx_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FLUSH = 2'd1,
        ST_RUN   = 2'd2
    } state_t;

    localparam logic [7:0] CFG_NONE = 8'd0;
    localparam logic [7:0] CFG_TOP  = 8'd1;
    localparam logic [7:0] CFG_TOP1 = 8'd2;

    function automatic logic cfg_valid(input logic [7:0] id);
        return (id == CFG_TOP) || (id == CFG_TOP1);
    endfunction

    // A size of zero means "no frame", so out_last can never assert.
    function automatic logic [15:0] frame_size(input logic [7:0] id,
                                               input logic [15:0] f1,
                                               input logic [15:0] f2);
        case (id)
            CFG_TOP:  return f1;
            CFG_TOP1: return f2;
            default:  return 16'd0;
        endcase
    endfunction

endpackage

// File: rtl/mdc_rx_fifo.sv
// DEPTH x DATA_W first-word-fall-through FIFO with synchronous clear and
// synchronous active-low reset; the head is forced to zero while empty.
module mdc_rx_fifo #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 16
) (
    input  logic                      i_clk,
    input  logic                      i_rst_n,
    input  logic                      i_clr,
    input  logic                      i_wr,
    input  logic [DATA_W-1:0]         i_wr_data,
    input  logic                      i_rd,
    output logic [DATA_W-1:0]         o_rd_data,
    output logic [$clog2(DEPTH):0]    o_count,
    output logic                      o_empty_n
);
    localparam int AW = $clog2(DEPTH);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [AW-1:0]     r_wr_ptr;
    logic [AW-1:0]     r_rd_ptr;
    logic [AW:0]       r_count;
    logic              w_wr;
    logic              w_rd;

    assign w_wr      = i_wr && (r_count != (AW+1)'(DEPTH));
    assign w_rd      = i_rd && (r_count != '0);
    assign o_count   = r_count;
    assign o_empty_n = (r_count != '0);
    assign o_rd_data = o_empty_n ? r_mem[r_rd_ptr] : '0;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n || i_clr) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_wr) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_rd) r_rd_ptr <= r_rd_ptr + AW'(1);
            r_count <= r_count + (AW+1)'(w_wr) - (AW+1)'(w_rd);
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_wr) r_mem[r_wr_ptr] <= i_wr_data;
    end

endmodule

// File: rtl/mdc_stream_receiver.sv
// Reader end of a multi_dataflow output port: FIFO buffering, frame delimiting per ID.
// Optional per-frame checksum ports are enabled by defining MDC_RX_CHECKSUM_EN.
module mdc_stream_receiver
    import mdc_rx_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int DEPTH      = 16,
    parameter int FRAME_CFG1 = 64,
    parameter int FRAME_CFG2 = 64
) (
    input  logic              ap_clk,
    input  logic              ap_rst,
    input  logic [7:0]        ID,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_write,
    output logic              in_full_n,
    output logic [DATA_W-1:0] out_data,
    output logic              out_empty_n,
    input  logic              out_read,
    output logic              out_last,
    output logic [15:0]       frame_cnt,
    output logic              overflow
`ifdef MDC_RX_CHECKSUM_EN
    ,
    output logic [DATA_W-1:0] chk_sum,
    output logic              chk_valid
`endif
);
    localparam int CW = $clog2(DEPTH) + 1;

    state_t        r_state;
    state_t        w_state_nxt;
    logic [7:0]    r_id;
    logic          r_full_n;
    logic [15:0]   r_tok_cnt;
    logic [15:0]   r_frame_cnt;
    logic          r_overflow;
    logic [15:0]   w_frame;
    logic          w_clear;
    logic          w_wr;
    logic          w_rd;
    logic          w_last;
    logic [CW-1:0] w_count;
    logic [CW-1:0] w_cnt_nxt;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:  if (cfg_valid(ID)) w_state_nxt = ST_FLUSH;
            ST_FLUSH: w_state_nxt = ST_RUN;
            ST_RUN: begin
                if (!cfg_valid(ID))   w_state_nxt = ST_IDLE;
                else if (ID != r_id)  w_state_nxt = ST_FLUSH;
            end
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    // Clearing on the edge into FLUSH as well as the edge out of it keeps the FIFO empty for the whole FLUSH cycle.
    assign w_clear   = (w_state_nxt == ST_FLUSH) || (r_state == ST_FLUSH);
    assign w_wr      = in_write && r_full_n && !w_clear;
    assign w_rd      = out_read && out_empty_n && !w_clear;
    assign w_cnt_nxt = w_clear ? '0 : (w_count + CW'(w_wr) - CW'(w_rd));
    assign w_frame   = frame_size(r_id, FRAME_CFG1[15:0], FRAME_CFG2[15:0]);
    assign w_last    = out_empty_n && (w_frame != 16'd0) && (r_tok_cnt == w_frame - 16'd1);

    mdc_rx_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .i_clk     (ap_clk),
        .i_rst_n   (ap_rst),
        .i_clr     (w_clear),
        .i_wr      (w_wr),
        .i_wr_data (in_data),
        .i_rd      (w_rd),
        .o_rd_data (out_data),
        .o_count   (w_count),
        .o_empty_n (out_empty_n)
    );

    always_ff @(posedge ap_clk) begin
        if (!ap_rst) begin
            r_state     <= ST_IDLE;
            r_id        <= CFG_NONE;
            r_full_n    <= 1'b0;
            r_tok_cnt   <= 16'd0;
            r_frame_cnt <= 16'd0;
            r_overflow  <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_full_n <= (w_state_nxt == ST_RUN) && (w_cnt_nxt != CW'(DEPTH));
            if (w_state_nxt == ST_FLUSH && r_state != ST_FLUSH) r_id <= ID;
            // A read freeing a slot this cycle does not rescue a write seen while full.
            if (r_state == ST_RUN && in_write && !r_full_n) r_overflow <= 1'b1;
            if (w_clear) begin
                r_tok_cnt   <= 16'd0;
                r_frame_cnt <= 16'd0;
            end else if (w_rd) begin
                if (w_last) begin
                    r_tok_cnt   <= 16'd0;
                    r_frame_cnt <= r_frame_cnt + 16'd1;
                end else begin
                    r_tok_cnt   <= r_tok_cnt + 16'd1;
                end
            end
        end
    end

    assign in_full_n = r_full_n;
    assign out_last  = w_last;
    assign frame_cnt = r_frame_cnt;
    assign overflow  = r_overflow;

`ifdef MDC_RX_CHECKSUM_EN
    logic [DATA_W-1:0] r_acc;
    logic [DATA_W-1:0] r_chk_sum;
    logic              r_chk_valid;
    logic [DATA_W-1:0] w_sum;

    assign w_sum = r_acc + out_data;

    always_ff @(posedge ap_clk) begin
        if (!ap_rst || w_clear) begin
            r_acc       <= '0;
            r_chk_sum   <= '0;
            r_chk_valid <= 1'b0;
        end else begin
            r_chk_valid <= w_rd && w_last;
            if (w_rd) begin
                r_chk_sum <= w_sum;
                r_acc     <= w_last ? '0 : w_sum;
            end
        end
    end

    assign chk_sum   = r_chk_sum;
    assign chk_valid = r_chk_valid;
`endif

endmodule

// File: tb/tb_mdc_stream_receiver.sv
// Directed plus randomized bench for mdc_stream_receiver against a queue-based reference model.
module tb_mdc_stream_receiver;
    localparam int DW    = 32;
    localparam int DEPTH = 16;
    localparam int F1    = 64;
    localparam int F2    = 24;

    logic          ap_clk = 1'b0;
    logic          ap_rst = 1'b0;
    logic [7:0]    ID = 8'd0;
    logic [DW-1:0] in_data = '0;
    logic          in_write = 1'b0;
    logic          in_full_n;
    logic [DW-1:0] out_data;
    logic          out_empty_n;
    logic          out_read = 1'b0;
    logic          out_last;
    logic [15:0]   frame_cnt;
    logic          overflow;
`ifdef MDC_RX_CHECKSUM_EN
    logic [DW-1:0] chk_sum;
    logic          chk_valid;
`endif

    mdc_stream_receiver #(
        .DATA_W(DW), .DEPTH(DEPTH), .FRAME_CFG1(F1), .FRAME_CFG2(F2)
    ) dut (
        .ap_clk(ap_clk), .ap_rst(ap_rst), .ID(ID),
        .in_data(in_data), .in_write(in_write), .in_full_n(in_full_n),
        .out_data(out_data), .out_empty_n(out_empty_n), .out_read(out_read),
        .out_last(out_last), .frame_cnt(frame_cnt), .overflow(overflow)
`ifdef MDC_RX_CHECKSUM_EN
        , .chk_sum(chk_sum), .chk_valid(chk_valid)
`endif
    );

    always #5 ap_clk = ~ap_clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: buffered tokens, position in frame, completed frames.
    logic [DW-1:0] q[$];
    int            tokcnt = 0;
    int            m_frame = F1;
    logic [15:0]   frames = 16'd0;
    bit            ovf = 1'b0;
    bit            m_run = 1'b0;
    logic [DW-1:0] msum = '0;
    logic [DW-1:0] exp_sum = '0;
    bit            exp_cv = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        bit ne;
        ne = (q.size() > 0);
        chk({tag, ".empty_n"}, 32'(out_empty_n), 32'(ne));
        chk({tag, ".data"}, out_data, ne ? q[0] : 32'd0);
        chk({tag, ".last"}, 32'(out_last), 32'(ne && (tokcnt == m_frame - 1)));
        chk({tag, ".full_n"}, 32'(in_full_n), 32'(m_run && (q.size() < DEPTH)));
        chk({tag, ".frame_cnt"}, 32'(frame_cnt), 32'(frames));
        chk({tag, ".overflow"}, 32'(overflow), 32'(ovf));
`ifdef MDC_RX_CHECKSUM_EN
        chk({tag, ".chk_valid"}, 32'(chk_valid), 32'(exp_cv));
        chk({tag, ".chk_sum"}, chk_sum, exp_sum);
`endif
    endtask

    task automatic tick(input string tag, input bit w, input logic [DW-1:0] d, input bit r);
        bit            ra;
        bit            wa;
        logic [DW-1:0] tok;
        logic [DW-1:0] s;
        in_write = w;
        in_data  = d;
        out_read = r;
        ra = r && (q.size() > 0);
        wa = w && m_run && (q.size() < DEPTH);
        if (w && m_run && !wa) ovf = 1'b1;
        exp_cv = 1'b0;
        if (ra) begin
            tok = q.pop_front();
            s = msum + tok;
            exp_sum = s;
            if (tokcnt == m_frame - 1) begin
                tokcnt = 0;
                frames = frames + 16'd1;
                exp_cv = 1'b1;
                msum = '0;
            end else begin
                tokcnt++;
                msum = s;
            end
        end
        if (wa) q.push_back(d);
        @(posedge ap_clk);
        #1;
        check_all(tag);
    endtask

    task automatic model_clear();
        q.delete();
        tokcnt  = 0;
        frames  = 16'd0;
        msum    = '0;
        exp_sum = '0;
        exp_cv  = 1'b0;
        m_run   = 1'b0;
    endtask

    // Apply a new ID: one FLUSH cycle, then RUN.
    task automatic cfg(input string tag, input logic [7:0] id);
        ID = id;
        in_write = 1'b0;
        out_read = 1'b0;
        @(posedge ap_clk);
        #1;
        model_clear();
        check_all({tag, ".flush"});
        @(posedge ap_clk);
        #1;
        m_run   = 1'b1;
        m_frame = (id == 8'd1) ? F1 : F2;
        check_all({tag, ".run"});
    endtask

    task automatic do_reset(input string tag);
        ap_rst = 1'b0;
        in_write = 1'b0;
        out_read = 1'b0;
        @(posedge ap_clk);
        #1;
        model_clear();
        ovf = 1'b0;
        check_all(tag);
        chk({tag, ".data0"}, out_data, 32'd0);
        ap_rst = 1'b1;
    endtask

    task automatic random_run(input string tag, input int n);
        for (int i = 0; i < n; i++)
            tick(tag, ($urandom_range(0, 3) != 0), $urandom, ($urandom_range(0, 3) != 0));
    endtask

    int pulses;

    initial begin
        // Reset state
        do_reset("t0.reset");

        // 1: one full frame of 0..63 streamed through
        cfg("t1.cfg", 8'd1);
        for (int i = 0; i < 64; i++) tick("t1.stream", 1'b1, DW'(i), 1'b1);
        tick("t1.drain", 1'b0, '0, 1'b1);
        tick("t1.drain", 1'b0, '0, 1'b1);
        chk("t1.frames", 32'(frame_cnt), 32'd1);
        chk("t1.overflow", 32'(overflow), 32'd0);

        // 2: 20 writes into a 16-deep FIFO, no reads
        for (int i = 0; i < 20; i++) tick("t2.fill", 1'b1, DW'(i), 1'b0);
        chk("t2.full_n", 32'(in_full_n), 32'd0);
        chk("t2.overflow", 32'(overflow), 32'd1);
        for (int i = 0; i < 17; i++) tick("t2.read", 1'b0, '0, 1'b1);

        // 3: full FIFO with simultaneous read and write
        do_reset("t3.reset");
        cfg("t3.cfg", 8'd1);
        for (int i = 0; i < 16; i++) tick("t3.fill", 1'b1, DW'(100 + i), 1'b0);
        tick("t3.rw", 1'b1, 32'hdead, 1'b1);
        chk("t3.overflow", 32'(overflow), 32'd1);
        chk("t3.full_n", 32'(in_full_n), 32'd1);
        for (int i = 0; i < 16; i++) tick("t3.drain", 1'b0, '0, 1'b1);

        // 4: ID change with tokens buffered, then frames of F2
        do_reset("t4.reset");
        cfg("t4.cfg1", 8'd1);
        for (int i = 0; i < 5; i++) tick("t4.fill", 1'b1, DW'(i), 1'b0);
        cfg("t4.cfg2", 8'd2);
        random_run("t4.rand", 200);

        // 5: reset mid-frame with 8 tokens buffered
        cfg("t5.cfg", 8'd1);
        random_run("t5.pre", 20);
        for (int i = 0; i < 16; i++) tick("t5.drain", 1'b0, '0, 1'b1);
        for (int i = 0; i < 8; i++) tick("t5.fill", 1'b1, $urandom, 1'b0);
        do_reset("t5.reset");
        cfg("t5.recfg", 8'd1);
        random_run("t5.rand", 250);

`ifdef MDC_RX_CHECKSUM_EN
        // 6: checksum over a frame of ones
        do_reset("t6.reset");
        cfg("t6.cfg", 8'd1);
        pulses = 0;
        for (int i = 0; i < 66; i++) begin
            tick("t6.stream", (i < 64), 32'h1, 1'b1);
            if (chk_valid) begin
                pulses++;
                chk("t6.sum", chk_sum, 32'd64);
            end
        end
        chk("t6.pulses", 32'(pulses), 32'd1);
        random_run("t6.rand", 150);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
